// File: rtl/ps2_scancode_to_ascii_if.sv
// Character stream from the scancode decoder to the text-buffer/editor stage.
// The decoder drives the master side and the consumer drives the slave side.
interface ps2_scancode_to_ascii_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_out, output char_valid, input char_ready);
  modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/ps2_scancode_to_ascii.sv
// Turns PS/2 set-2 byte strobes into ASCII characters. It tracks the break and
// extended prefixes and the Shift and Caps Lock state, and buffers characters in a FIFO.
module ps2_scancode_to_ascii #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     data_in,
  input  logic                           key_pressed,
  input  logic                           enter_pressed,
  input  logic                           bksp_pressed,
  input  logic                           break_entered,
  ps2_scancode_to_ascii_if.master        char_if,
  output logic                           shift_active,
  output logic                           caps_active,
  output logic                           overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_MAKE, S_BREAK, S_EXT, S_EXTBRK} state_t;

  // Returns {mapped, ascii}. Case applies to letters only; other keys follow Shift alone.
  function automatic logic [8:0] f_map(input logic [7:0] code, input logic shift,
                                       input logic caps);
    logic [7:0] lo;
    logic [7:0] hi;
    logic       upper;
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: lo = 8'h61;  8'h32: lo = 8'h62;  8'h21: lo = 8'h63;  8'h23: lo = 8'h64;
      8'h24: lo = 8'h65;  8'h2B: lo = 8'h66;  8'h34: lo = 8'h67;  8'h33: lo = 8'h68;
      8'h43: lo = 8'h69;  8'h3B: lo = 8'h6A;  8'h42: lo = 8'h6B;  8'h4B: lo = 8'h6C;
      8'h3A: lo = 8'h6D;  8'h31: lo = 8'h6E;  8'h44: lo = 8'h6F;  8'h4D: lo = 8'h70;
      8'h15: lo = 8'h71;  8'h2D: lo = 8'h72;  8'h1B: lo = 8'h73;  8'h2C: lo = 8'h74;
      8'h3C: lo = 8'h75;  8'h2A: lo = 8'h76;  8'h1D: lo = 8'h77;  8'h22: lo = 8'h78;
      8'h35: lo = 8'h79;  8'h1A: lo = 8'h7A;
      8'h16: begin lo = 8'h31; hi = 8'h21; end
      8'h1E: begin lo = 8'h32; hi = 8'h40; end
      8'h26: begin lo = 8'h33; hi = 8'h23; end
      8'h25: begin lo = 8'h34; hi = 8'h24; end
      8'h2E: begin lo = 8'h35; hi = 8'h25; end
      8'h36: begin lo = 8'h36; hi = 8'h5E; end
      8'h3D: begin lo = 8'h37; hi = 8'h26; end
      8'h3E: begin lo = 8'h38; hi = 8'h2A; end
      8'h46: begin lo = 8'h39; hi = 8'h28; end
      8'h45: begin lo = 8'h30; hi = 8'h29; end
      8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      8'h55: begin lo = 8'h3D; hi = 8'h2B; end
      8'h41: begin lo = 8'h2C; hi = 8'h3C; end
      8'h49: begin lo = 8'h2E; hi = 8'h3E; end
      8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
      8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h29: lo = 8'h20;
      8'h5A: lo = 8'h0D;
      8'h66: lo = 8'h08;
      default: ;
    endcase
    if (lo >= 8'h61 && lo <= 8'h7A) begin
      hi    = lo - 8'h20;
      upper = shift ^ caps;
    end else begin
      upper = shift;
      if (hi == 8'h00) hi = lo;
    end
    return {lo != 8'h00, upper ? hi : lo};
  endfunction

  state_t          r_state, w_state_nxt;
  logic            r_lshift, r_rshift, r_caps;
  logic            w_lshift_nxt, w_rshift_nxt, w_caps_nxt;
  logic            r_shift_active, r_overflow, r_char_valid;
  logic [7:0]      r_char_out;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]   r_count, w_count_nxt, w_count_after_pop;
  logic            w_strobe, w_push, w_push_ok, w_pop, w_full, w_ovf_set;
  logic [7:0]      w_byte, w_push_data, w_head_nxt;
  logic [8:0]      w_map;

  // Priority among strobes: break > enter > bksp > key.
  assign w_strobe = key_pressed | enter_pressed | bksp_pressed | break_entered;
  assign w_byte   = break_entered ? 8'hF0 :
                    enter_pressed ? 8'h5A :
                    bksp_pressed  ? 8'h66 : data_in;
  assign w_map    = f_map(w_byte, r_lshift | r_rshift, r_caps);

  always_comb begin
    w_state_nxt  = r_state;
    w_lshift_nxt = r_lshift;
    w_rshift_nxt = r_rshift;
    w_caps_nxt   = r_caps;
    w_push       = 1'b0;
    w_push_data  = 8'h00;
    if (w_strobe) begin
      case (r_state)
        S_MAKE: begin
          if (w_byte == 8'hF0)      w_state_nxt  = S_BREAK;
          else if (w_byte == 8'hE0) w_state_nxt  = S_EXT;
          else if (w_byte == 8'h12) w_lshift_nxt = 1'b1;
          else if (w_byte == 8'h59) w_rshift_nxt = 1'b1;
          else if (w_byte == 8'h58) w_caps_nxt   = ~r_caps;
          else begin
            w_push      = w_map[8];
            w_push_data = w_map[7:0];
          end
        end
        S_BREAK: begin
          if (w_byte == 8'h12) w_lshift_nxt = 1'b0;
          if (w_byte == 8'h59) w_rshift_nxt = 1'b0;
          w_state_nxt = S_MAKE;
        end
        S_EXT:    w_state_nxt = (w_byte == 8'hF0) ? S_EXTBRK : S_MAKE;
        default:  w_state_nxt = S_MAKE;
      endcase
    end
  end

  assign w_full    = (r_count == LP_FULL);
  assign w_pop     = r_char_valid & char_if.char_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // The head register is loaded with the next head so char_out is registered and stable.
  always_comb begin
    w_rd_ptr_nxt      = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
    w_count_after_pop = w_pop ? r_count - CW'(1) : r_count;
    w_count_nxt       = w_push_ok ? w_count_after_pop + CW'(1) : w_count_after_pop;
    w_head_nxt        = 8'h00;
    if (w_count_nxt != '0) begin
      if (w_count_after_pop == '0) w_head_nxt = w_push_data;
      else                         w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_MAKE;
      r_lshift       <= 1'b0;
      r_rshift       <= 1'b0;
      r_caps         <= 1'b0;
      r_shift_active <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_char_valid   <= 1'b0;
      r_char_out     <= 8'h00;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_lshift       <= w_lshift_nxt;
      r_rshift       <= w_rshift_nxt;
      r_caps         <= w_caps_nxt;
      r_shift_active <= w_lshift_nxt | w_rshift_nxt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_char_valid   <= (w_count_nxt != '0);
      r_char_out     <= w_head_nxt;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign char_if.char_out   = r_char_out;
  assign char_if.char_valid = r_char_valid;
  assign shift_active       = r_shift_active;
  assign caps_active        = r_caps;
  assign overflow           = r_overflow;

endmodule
